// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the PWM bank: register map addresses, CTRL bit
// positions and the period counter state encoding.
// No ports; imported by pwm_channel and pwm_bank.
// -----------------------------------------------------------------------------
package pwm_pkg;

  // Register map, word addresses on the configuration bus
  localparam int ADDR_CTRL      = 0;
  localparam int ADDR_PERIOD    = 1;
  localparam int ADDR_PRESC     = 2;
  localparam int ADDR_INV       = 3;
  localparam int ADDR_DUTY_BASE = 4;

  // Bit positions inside CTRL
  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_CENTER_BIT = 1;

  // Period counter state: IDLE while disabled, DOWN only in center mode
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } cnt_state_e;

endpackage

// File: rtl/pwm_channel.sv
// -----------------------------------------------------------------------------
// pwm_channel
// One PWM compare channel: shadow and active duty registers, compare against
// the shared period counter, output inversion and the registered output.
// Ports:
//   clk_io    in   1      system clock
//   reset_io  in   1      synchronous reset, active-low
//   en        in   1      global enable; when low the output idles at inv
//   load      in   1      copy shadow duty into active duty this cycle
//   wr        in   1      write strobe for this channel's duty register
//   wr_data   in   CNT_W  new duty value
//   cnt       in   CNT_W  shared period counter
//   inv       in   1      active inversion bit for this channel
//   duty_sh   out  CNT_W  shadow duty, used for readback
//   pwm_out   out  1      registered PWM output
// -----------------------------------------------------------------------------
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk_io,
  input  logic             reset_io,
  input  logic             en,
  input  logic             load,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_data,
  input  logic [CNT_W-1:0] cnt,
  input  logic             inv,
  output logic [CNT_W-1:0] duty_sh,
  output logic             pwm_out
);

  logic [CNT_W-1:0] duty_act;

  // Duty is double-buffered: the bus writes the shadow copy at any time,
  // while the comparator only ever sees the active copy, which is refreshed
  // on a period boundary (or continuously while disabled). The output flop
  // compares the current counter value, so pwm_out trails cnt by one clock.
  // A write landing on a load cycle still sees the old shadow being copied.
  always_ff @(posedge clk_io) begin
    if (!reset_io) begin
      duty_sh  <= '0;
      duty_act <= '0;
      pwm_out  <= 1'b0;
    end else begin
      if (wr) begin
        duty_sh <= wr_data;
      end
      if (load) begin
        duty_act <= duty_sh;
      end
      if (!en) begin
        pwm_out <= inv;
      end else begin
        pwm_out <= (cnt < duty_act) ^ inv;
      end
    end
  end

endmodule

// File: rtl/pwm_bank.sv
// -----------------------------------------------------------------------------
// pwm_bank
// Multi-channel PWM generator. A shared prescaler and period counter (edge-
// or center-aligned) drive NUM_CH compare channels. Configuration is written
// over a 16-bit register bus into shadow registers that are transferred to
// the active set only at period boundaries, so outputs never glitch mid-period.
// Ports:
//   clk_io       in   1       system clock
//   reset_io     in   1       synchronous reset, active-low
//   wr_en        in   1       register write strobe
//   wr_addr      in   ADDR_W  register write address
//   wr_data      in   16      write data, unused upper bits ignored
//   rd_addr      in   ADDR_W  readback address
//   rd_data      out  16      shadow register readback, one cycle latency
//   pwm_out      out  NUM_CH  registered PWM outputs
//   period_tick  out  1       one-cycle pulse with the first output cycle
//                             of each new period
// -----------------------------------------------------------------------------
module pwm_bank
  import pwm_pkg::*;
#(
  parameter int NUM_CH  = 8,
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 8,
  parameter int ADDR_W  = 5
) (
  input  logic              clk_io,
  input  logic              reset_io,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [15:0]       rd_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_tick
);

  logic               ctrl_en;
  logic               center_sh, center_act;
  logic [CNT_W-1:0]   period_sh, period_act;
  logic [PRESC_W-1:0] presc_sh, presc_act;
  logic [NUM_CH-1:0]  inv_sh, inv_act;
  logic [CNT_W-1:0]   duty_sh [NUM_CH];

  logic               wr_ctrl, wr_period, wr_presc, wr_inv;
  logic               tick, boundary, boundary_d, load;
  logic [PRESC_W-1:0] pc, pc_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  cnt_state_e         state, state_next;
  logic [15:0]        rd_next;
  logic               unused_wr_bits;

  // Narrow configurations leave upper write-data bits unconnected on purpose
  assign unused_wr_bits = ^wr_data;

  assign wr_ctrl   = wr_en && (wr_addr == ADDR_W'(ADDR_CTRL));
  assign wr_period = wr_en && (wr_addr == ADDR_W'(ADDR_PERIOD));
  assign wr_presc  = wr_en && (wr_addr == ADDR_W'(ADDR_PRESC));
  assign wr_inv    = wr_en && (wr_addr == ADDR_W'(ADDR_INV));

  // While disabled the active set tracks the shadow set every cycle, so
  // enabling always starts from the most recently written configuration.
  assign load = boundary || !ctrl_en;

  // Global shadow registers and their active copies. EN is deliberately
  // not double-buffered so that start/stop take effect immediately.
  always_ff @(posedge clk_io) begin
    if (!reset_io) begin
      ctrl_en    <= 1'b0;
      center_sh  <= 1'b0;
      center_act <= 1'b0;
      period_sh  <= '0;
      period_act <= '0;
      presc_sh   <= '0;
      presc_act  <= '0;
      inv_sh     <= '0;
      inv_act    <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en   <= wr_data[CTRL_EN_BIT];
        center_sh <= wr_data[CTRL_CENTER_BIT];
      end
      if (wr_period) begin
        period_sh <= wr_data[CNT_W-1:0];
      end
      if (wr_presc) begin
        presc_sh <= wr_data[PRESC_W-1:0];
      end
      if (wr_inv) begin
        inv_sh <= wr_data[NUM_CH-1:0];
      end
      if (load) begin
        center_act <= center_sh;
        period_act <= period_sh;
        presc_act  <= presc_sh;
        inv_act    <= inv_sh;
      end
    end
  end

  // Tick and boundary detection. In center mode the counter turns around
  // at the bottom while heading down; a zero period degenerates to a
  // boundary on every tick since the counter never leaves zero.
  always_comb begin
    tick     = ctrl_en && (pc == presc_act);
    boundary = 1'b0;
    if (!center_act) begin
      boundary = tick && (cnt == period_act);
    end else if (period_act == '0) begin
      boundary = tick;
    end else begin
      boundary = tick && (state == DOWN) && (cnt == '0);
    end
  end

  // Counter next-state logic. Edge mode counts 0..PERIOD and wraps.
  // Center mode climbs to PERIOD-1, holds one tick while turning to DOWN,
  // descends to 0 and holds one tick while turning back to UP, giving a
  // 2*PERIOD tick period whose pulses straddle the bottom turnaround.
  // IDLE behaves like UP on the first enabled cycle so counting starts
  // immediately from zero.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pc_next    = pc;
    if (!ctrl_en) begin
      state_next = IDLE;
      cnt_next   = '0;
      pc_next    = '0;
    end else begin
      pc_next = tick ? '0 : pc + PRESC_W'(1);
      if (state == IDLE) begin
        state_next = UP;
      end
      if (tick) begin
        if (!center_act) begin
          state_next = UP;
          cnt_next   = (cnt == period_act) ? '0 : cnt + CNT_W'(1);
        end else if (period_act == '0) begin
          state_next = UP;
          cnt_next   = '0;
        end else if (state != DOWN) begin
          if (cnt == period_act - CNT_W'(1)) begin
            state_next = DOWN;
          end else begin
            state_next = UP;
            cnt_next   = cnt + CNT_W'(1);
          end
        end else begin
          if (cnt == '0) begin
            state_next = UP;
          end else begin
            cnt_next = cnt - CNT_W'(1);
          end
        end
      end
    end
  end

  // Counter state register. period_tick is delayed twice from the boundary
  // so it lines up with the first registered output of the new period.
  always_ff @(posedge clk_io) begin
    if (!reset_io) begin
      state       <= IDLE;
      cnt         <= '0;
      pc          <= '0;
      boundary_d  <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      pc          <= pc_next;
      boundary_d  <= boundary;
      period_tick <= boundary_d && ctrl_en;
    end
  end

  // One compare channel per output, each owning its own duty registers
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic duty_wr;
    assign duty_wr = wr_en && (wr_addr == ADDR_W'(ADDR_DUTY_BASE + k));

    pwm_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk_io  (clk_io),
      .reset_io(reset_io),
      .en      (ctrl_en),
      .load    (load),
      .wr      (duty_wr),
      .wr_data (wr_data[CNT_W-1:0]),
      .cnt     (cnt),
      .inv     (inv_act[k]),
      .duty_sh (duty_sh[k]),
      .pwm_out (pwm_out[k])
    );
  end

  // Readback multiplexer over the shadow registers; unmapped addresses read
  // zero. Registering it means a same-cycle write shows the old value.
  always_comb begin
    rd_next = '0;
    if (rd_addr == ADDR_W'(ADDR_CTRL)) begin
      rd_next = 16'({center_sh, ctrl_en});
    end else if (rd_addr == ADDR_W'(ADDR_PERIOD)) begin
      rd_next = 16'(period_sh);
    end else if (rd_addr == ADDR_W'(ADDR_PRESC)) begin
      rd_next = 16'(presc_sh);
    end else if (rd_addr == ADDR_W'(ADDR_INV)) begin
      rd_next = 16'(inv_sh);
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (rd_addr == ADDR_W'(ADDR_DUTY_BASE + k)) begin
        rd_next = 16'(duty_sh[k]);
      end
    end
  end

  // Readback output register
  always_ff @(posedge clk_io) begin
    if (!reset_io) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_next;
    end
  end

endmodule
